// File: rtl/mem_stage_pkg.sv
// Shared definitions for the MIPS memory-access stage: FSM state encoding,
// access size encoding and the default ack timeout.
package mem_stage_pkg;

  typedef enum logic {
    StIdle = 1'b0,
    StWait = 1'b1
  } state_e;

  localparam logic [1:0] SzByte = 2'b00;
  localparam logic [1:0] SzHalf = 2'b01;
  localparam logic [1:0] SzWord = 2'b10;

  localparam int unsigned DefaultTimeout = 16;
  // Wait counter width; covers the full legal TIMEOUT range 1..255.
  localparam int unsigned CntW = 8;

endpackage

// File: rtl/mem_stage_load_extend.sv
// Load lane select plus sign/zero extension for sub-word loads.
// Only instantiated by mem_stage when MEM_BYTE_EN is defined.
module mem_stage_load_extend
  import mem_stage_pkg::*;
(
  input  logic [31:0] rdata_i,
  input  logic [1:0]  addr_lo_i,
  input  logic [1:0]  size_i,
  input  logic        unsigned_i,
  output logic [31:0] data_o
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  // Pick the addressed lane, then extend it to 32 bits.
  always_comb begin
    unique case (addr_lo_i)
      2'd0:    byte_sel = rdata_i[7:0];
      2'd1:    byte_sel = rdata_i[15:8];
      2'd2:    byte_sel = rdata_i[23:16];
      default: byte_sel = rdata_i[31:24];
    endcase
    half_sel = addr_lo_i[1] ? rdata_i[31:16] : rdata_i[15:0];

    case (size_i)
      SzByte:  data_o = {{24{byte_sel[7] & ~unsigned_i}}, byte_sel};
      SzHalf:  data_o = {{16{half_sel[15] & ~unsigned_i}}, half_sel};
      default: data_o = rdata_i;
    endcase
  end

endmodule

// File: rtl/mem_stage.sv
// MIPS memory-access stage: drives a req/ack data-memory port from the EX/MEM
// register, stalls upstream while an access is outstanding, aborts after
// TIMEOUT wait cycles and produces the registered MEM/WB values.
// Optional feature macro: MEM_BYTE_EN (byte/half accesses, size_m/unsigned_m).
module mem_stage
  import mem_stage_pkg::*;
#(
  parameter int unsigned TIMEOUT = DefaultTimeout
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        regwrite_m,
  input  logic        memtoreg_m,
  input  logic        memwrite_m,
  input  logic        memread_m,
  input  logic [31:0] aluout_m,
  input  logic [31:0] writedata_m,
  input  logic [4:0]  writereg_m,
`ifdef MEM_BYTE_EN
  input  logic [1:0]  size_m,
  input  logic        unsigned_m,
`endif
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [31:0] dmem_wdata,
  output logic [3:0]  dmem_be,
  input  logic        dmem_ack,
  input  logic [31:0] dmem_rdata,
  output logic        stall_m,
  output logic        regwrite_w,
  output logic        memtoreg_w,
  output logic [31:0] readdata_w,
  output logic [31:0] aluout_w,
  output logic [4:0]  writereg_w,
  output logic        misalign_w,
  output logic        buserr_w
);

  localparam logic [CntW-1:0] TimeoutCnt = CntW'(TIMEOUT);

  state_e          state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;

  logic        access;
  logic        misalign;
  logic        misalign_ev;
  logic        waiting;
  logic        req;
  logic        done;
  logic        timeout;
  logic        stall;
  logic [3:0]  be;
  logic [31:0] wdata;
  logic [31:0] ext_rdata;

  // Access decode, misalignment check and lane/byte-enable generation.
  always_comb begin
    access = memread_m | memwrite_m;
`ifdef MEM_BYTE_EN
    case (size_m)
      SzByte: begin
        misalign = 1'b0;
        be       = 4'b0001 << aluout_m[1:0];
        wdata    = {4{writedata_m[7:0]}};
      end
      SzHalf: begin
        misalign = aluout_m[0];
        be       = aluout_m[1] ? 4'b1100 : 4'b0011;
        wdata    = {2{writedata_m[15:0]}};
      end
      default: begin
        misalign = |aluout_m[1:0];
        be       = 4'hF;
        wdata    = writedata_m;
      end
    endcase
`else
    misalign = |aluout_m[1:0];
    be       = 4'hF;
    wdata    = writedata_m;
`endif
  end

  // Handshake: reset drops the request in the same cycle it is sampled.
  always_comb begin
    waiting     = (state_q == StWait);
    misalign_ev = ~waiting & access & misalign;
    req         = ~reset & (waiting | (access & ~misalign));
    done        = req & dmem_ack;
    // An ack in the TIMEOUT cycle wins over the abort.
    timeout     = ~reset & waiting & (cnt_q == TimeoutCnt) & ~dmem_ack;
    stall       = req & ~dmem_ack & ~timeout;

    dmem_req    = req;
    dmem_we     = req & memwrite_m;
    dmem_addr   = req ? {aluout_m[31:2], 2'b00} : 32'h0;
    dmem_wdata  = req ? wdata : 32'h0;
    dmem_be     = req ? be : 4'h0;
    stall_m     = stall;
  end

`ifdef MEM_BYTE_EN
  mem_stage_load_extend u_load_extend (
    .rdata_i    (dmem_rdata),
    .addr_lo_i  (aluout_m[1:0]),
    .size_i     (size_m),
    .unsigned_i (unsigned_m),
    .data_o     (ext_rdata)
  );
`else
  assign ext_rdata = dmem_rdata;
`endif

  // FSM next state and wait counter.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      StIdle: begin
        if (req && !dmem_ack) begin
          state_d = StWait;
          cnt_d   = CntW'(1);
        end
      end
      StWait: begin
        if (dmem_ack || timeout) begin
          state_d = StIdle;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      default: begin
        state_d = StIdle;
        cnt_d   = '0;
      end
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StIdle;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // MEM/WB register: bubble on stall, errors suppress the register write.
  always_ff @(posedge clk) begin
    if (reset) begin
      regwrite_w <= 1'b0;
      memtoreg_w <= 1'b0;
      readdata_w <= 32'h0;
      aluout_w   <= 32'h0;
      writereg_w <= 5'h0;
      misalign_w <= 1'b0;
      buserr_w   <= 1'b0;
    end else if (stall) begin
      regwrite_w <= 1'b0;
      memtoreg_w <= 1'b0;
      misalign_w <= 1'b0;
      buserr_w   <= 1'b0;
    end else begin
      regwrite_w <= regwrite_m & ~misalign_ev & ~timeout;
      memtoreg_w <= memtoreg_m;
      aluout_w   <= aluout_m;
      writereg_w <= writereg_m;
      misalign_w <= misalign_ev;
      buserr_w   <= timeout;
      if (done && !memwrite_m) begin
        readdata_w <= ext_rdata;
      end
    end
  end

endmodule

// File: tb/tb_mem_stage.sv
// Directed bench for mem_stage: single-cycle vector table plus hand-written
// wait-state, timeout, reset-in-WAIT and (with MEM_BYTE_EN) sub-word sequences.
module tb_mem_stage;

  localparam int unsigned Tmo = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        regwrite_m, memtoreg_m, memwrite_m, memread_m;
  logic [31:0] aluout_m, writedata_m;
  logic [4:0]  writereg_m;
`ifdef MEM_BYTE_EN
  logic [1:0]  size_m;
  logic        unsigned_m;
`endif
  logic        dmem_req, dmem_we, dmem_ack;
  logic [31:0] dmem_addr, dmem_wdata, dmem_rdata;
  logic [3:0]  dmem_be;
  logic        stall_m, regwrite_w, memtoreg_w, misalign_w, buserr_w;
  logic [31:0] readdata_w, aluout_w;
  logic [4:0]  writereg_w;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mem_stage #(.TIMEOUT(Tmo)) dut (
    .clk         (clk),
    .reset       (reset),
    .regwrite_m  (regwrite_m),
    .memtoreg_m  (memtoreg_m),
    .memwrite_m  (memwrite_m),
    .memread_m   (memread_m),
    .aluout_m    (aluout_m),
    .writedata_m (writedata_m),
    .writereg_m  (writereg_m),
`ifdef MEM_BYTE_EN
    .size_m      (size_m),
    .unsigned_m  (unsigned_m),
`endif
    .dmem_req    (dmem_req),
    .dmem_we     (dmem_we),
    .dmem_addr   (dmem_addr),
    .dmem_wdata  (dmem_wdata),
    .dmem_be     (dmem_be),
    .dmem_ack    (dmem_ack),
    .dmem_rdata  (dmem_rdata),
    .stall_m     (stall_m),
    .regwrite_w  (regwrite_w),
    .memtoreg_w  (memtoreg_w),
    .readdata_w  (readdata_w),
    .aluout_w    (aluout_w),
    .writereg_w  (writereg_w),
    .misalign_w  (misalign_w),
    .buserr_w    (buserr_w)
  );

  typedef struct {
    logic        rw, mtr, mw, mr;
    logic [31:0] alu, wd;
    logic [4:0]  wr;
    logic        ack;
    logic [31:0] rd;
    logic        e_req, e_we, e_stall;
    logic [31:0] e_addr;
    logic        e_rw, e_mtr;
    logic [31:0] e_alu, e_rdw;
    logic [4:0]  e_wr;
    logic        e_mis, e_berr;
  } vec_t;

  vec_t vecs[8];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic set_in(input logic rw, input logic mtr, input logic mw, input logic mr,
                        input logic [31:0] alu, input logic [31:0] wd, input logic [4:0] wr,
                        input logic ack, input logic [31:0] rd);
    regwrite_m  = rw;
    memtoreg_m  = mtr;
    memwrite_m  = mw;
    memread_m   = mr;
    aluout_m    = alu;
    writedata_m = wd;
    writereg_m  = wr;
    dmem_ack    = ack;
    dmem_rdata  = rd;
`ifdef MEM_BYTE_EN
    size_m      = 2'b10;
    unsigned_m  = 1'b0;
`endif
  endtask

  task automatic clear_in();
    set_in(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 5'h0, 1'b0, 32'h0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // rw mtr mw mr  alu  wd  wr  ack  rd | req we stall addr | rw mtr alu rdw wr mis berr
    vecs[0] = '{1'b1, 1'b0, 1'b0, 1'b0, 32'h1234, 32'h0, 5'h0A, 1'b0, 32'h0,
                1'b0, 1'b0, 1'b0, 32'h0,
                1'b1, 1'b0, 32'h1234, 32'h0, 5'h0A, 1'b0, 1'b0};
    vecs[1] = '{1'b1, 1'b1, 1'b0, 1'b1, 32'h100, 32'h0, 5'h03, 1'b1, 32'hDEADBEEF,
                1'b1, 1'b0, 1'b0, 32'h100,
                1'b1, 1'b1, 32'h100, 32'hDEADBEEF, 5'h03, 1'b0, 1'b0};
    vecs[2] = '{1'b0, 1'b0, 1'b1, 1'b0, 32'h304, 32'h55AA, 5'h00, 1'b1, 32'hDEADBEEF,
                1'b1, 1'b1, 1'b0, 32'h304,
                1'b0, 1'b0, 32'h304, 32'hDEADBEEF, 5'h00, 1'b0, 1'b0};
    vecs[3] = '{1'b1, 1'b1, 1'b0, 1'b1, 32'h102, 32'h0, 5'h05, 1'b1, 32'h11111111,
                1'b0, 1'b0, 1'b0, 32'h0,
                1'b0, 1'b1, 32'h102, 32'hDEADBEEF, 5'h05, 1'b1, 1'b0};
    vecs[4] = '{1'b1, 1'b0, 1'b0, 1'b0, 32'h7, 32'h0, 5'h01, 1'b1, 32'hCAFEF00D,
                1'b0, 1'b0, 1'b0, 32'h0,
                1'b1, 1'b0, 32'h7, 32'hDEADBEEF, 5'h01, 1'b0, 1'b0};
    vecs[5] = '{1'b0, 1'b0, 1'b1, 1'b1, 32'h408, 32'h0F0F, 5'h00, 1'b1, 32'hDEADBEEF,
                1'b1, 1'b1, 1'b0, 32'h408,
                1'b0, 1'b0, 32'h408, 32'hDEADBEEF, 5'h00, 1'b0, 1'b0};
    vecs[6] = '{1'b0, 1'b0, 1'b1, 1'b0, 32'h301, 32'h1, 5'h00, 1'b0, 32'h0,
                1'b0, 1'b0, 1'b0, 32'h0,
                1'b0, 1'b0, 32'h301, 32'hDEADBEEF, 5'h00, 1'b1, 1'b0};
    vecs[7] = '{1'b1, 1'b1, 1'b0, 1'b1, 32'h10C, 32'h0, 5'h1F, 1'b1, 32'h0BADC0DE,
                1'b1, 1'b0, 1'b0, 32'h10C,
                1'b1, 1'b1, 32'h10C, 32'h0BADC0DE, 5'h1F, 1'b0, 1'b0};

    // Reset state
    clear_in();
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_req", dmem_req, 1'b0);
    chk("rst_stall", stall_m, 1'b0);
    chk("rst_be", dmem_be, 4'h0);
    chk("rst_regwrite_w", regwrite_w, 1'b0);
    chk("rst_aluout_w", aluout_w, 32'h0);
    chk("rst_readdata_w", readdata_w, 32'h0);
    chk("rst_flags", {misalign_w, buserr_w, memtoreg_w}, 3'b000);
    @(negedge clk);
    reset = 1'b0;

    // Single-cycle vectors
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      set_in(vecs[i].rw, vecs[i].mtr, vecs[i].mw, vecs[i].mr, vecs[i].alu, vecs[i].wd,
             vecs[i].wr, vecs[i].ack, vecs[i].rd);
      #1;
      chk($sformatf("v%0d_req", i), dmem_req, vecs[i].e_req);
      chk($sformatf("v%0d_stall", i), stall_m, vecs[i].e_stall);
      if (vecs[i].e_req) begin
        chk($sformatf("v%0d_we", i), dmem_we, vecs[i].e_we);
        chk($sformatf("v%0d_addr", i), dmem_addr, vecs[i].e_addr);
        chk($sformatf("v%0d_be", i), dmem_be, 4'hF);
      end
      @(posedge clk);
      #1;
      chk($sformatf("v%0d_regwrite_w", i), regwrite_w, vecs[i].e_rw);
      chk($sformatf("v%0d_memtoreg_w", i), memtoreg_w, vecs[i].e_mtr);
      chk($sformatf("v%0d_aluout_w", i), aluout_w, vecs[i].e_alu);
      chk($sformatf("v%0d_readdata_w", i), readdata_w, vecs[i].e_rdw);
      chk($sformatf("v%0d_writereg_w", i), writereg_w, vecs[i].e_wr);
      chk($sformatf("v%0d_misalign_w", i), misalign_w, vecs[i].e_mis);
      chk($sformatf("v%0d_buserr_w", i), buserr_w, vecs[i].e_berr);
    end

    // Store with three wait cycles, ack on the fourth
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      set_in(1'b0, 1'b0, 1'b1, 1'b0, 32'h200, 32'h6790, 5'h00, (k == 3), 32'h0);
      #1;
      chk($sformatf("st_req%0d", k), dmem_req, 1'b1);
      chk($sformatf("st_we%0d", k), dmem_we, 1'b1);
      chk($sformatf("st_be%0d", k), dmem_be, 4'hF);
      chk($sformatf("st_addr%0d", k), dmem_addr, 32'h200);
      chk($sformatf("st_wdata%0d", k), dmem_wdata, 32'h6790);
      chk($sformatf("st_stall%0d", k), stall_m, (k < 3));
      @(posedge clk);
      #1;
      chk($sformatf("st_wb_rw%0d", k), regwrite_w, 1'b0);
      if (k < 3) begin
        chk($sformatf("st_bubble_mtr%0d", k), memtoreg_w, 1'b0);
        chk($sformatf("st_held_alu%0d", k), aluout_w, 32'h10C);
      end
    end
    chk("st_done_alu", aluout_w, 32'h200);
    chk("st_done_flags", {misalign_w, buserr_w}, 2'b00);

    // Timeout: no ack for TIMEOUT cycles
    for (int k = 0; k <= 4; k++) begin
      @(negedge clk);
      set_in(1'b1, 1'b1, 1'b0, 1'b1, 32'h500, 32'h0, 5'h02, 1'b0, 32'h0);
      #1;
      chk($sformatf("to_req%0d", k), dmem_req, 1'b1);
      chk($sformatf("to_stall%0d", k), stall_m, (k < 4));
      @(posedge clk);
      #1;
      if (k < 4) chk($sformatf("to_bubble%0d", k), regwrite_w, 1'b0);
    end
    chk("to_buserr_w", buserr_w, 1'b1);
    chk("to_regwrite_w", regwrite_w, 1'b0);
    @(negedge clk);
    clear_in();
    #1;
    chk("to_idle_req", dmem_req, 1'b0);
    chk("to_idle_stall", stall_m, 1'b0);
    @(posedge clk);
    #1;
    chk("to_buserr_clr", buserr_w, 1'b0);

    // Ack arriving in the TIMEOUT cycle counts as success
    for (int k = 0; k <= 4; k++) begin
      @(negedge clk);
      set_in(1'b1, 1'b1, 1'b0, 1'b1, 32'h600, 32'h0, 5'h04, (k == 4), 32'h600DD00D);
      #1;
      chk($sformatf("late_stall%0d", k), stall_m, (k < 4));
      @(posedge clk);
    end
    #1;
    chk("late_regwrite_w", regwrite_w, 1'b1);
    chk("late_buserr_w", buserr_w, 1'b0);
    chk("late_readdata_w", readdata_w, 32'h600DD00D);

    // Reset asserted while in WAIT
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      set_in(1'b1, 1'b1, 1'b0, 1'b1, 32'h700, 32'h0, 5'h06, 1'b0, 32'h0);
      @(posedge clk);
    end
    @(negedge clk);
    reset = 1'b1;
    #1;
    chk("rw_req_drop", dmem_req, 1'b0);
    chk("rw_stall_drop", stall_m, 1'b0);
    @(posedge clk);
    #1;
    chk("rw_regwrite_w", regwrite_w, 1'b0);
    chk("rw_aluout_w", aluout_w, 32'h0);
    chk("rw_readdata_w", readdata_w, 32'h0);
    chk("rw_writereg_w", writereg_w, 5'h0);
    @(negedge clk);
    reset = 1'b0;
    clear_in();
    #1;
    chk("rw_idle_req", dmem_req, 1'b0);
    chk("rw_idle_stall", stall_m, 1'b0);
    @(posedge clk);
    #1;
    chk("rw_no_completion", {regwrite_w, memtoreg_w}, 2'b00);

`ifdef MEM_BYTE_EN
    // Signed byte load from the top lane
    @(negedge clk);
    set_in(1'b1, 1'b1, 1'b0, 1'b1, 32'h103, 32'h0, 5'h07, 1'b1, 32'h80000000);
    size_m = 2'b00;
    #1;
    chk("sb_be", dmem_be, 4'b1000);
    chk("sb_addr", dmem_addr, 32'h100);
    @(posedge clk);
    #1;
    chk("sb_readdata_w", readdata_w, 32'hFFFFFF80);
    // Unsigned half load from the upper half
    @(negedge clk);
    set_in(1'b1, 1'b1, 1'b0, 1'b1, 32'h102, 32'h0, 5'h07, 1'b1, 32'h80010000);
    size_m     = 2'b01;
    unsigned_m = 1'b1;
    #1;
    chk("uh_be", dmem_be, 4'b1100);
    @(posedge clk);
    #1;
    chk("uh_readdata_w", readdata_w, 32'h00008001);
    chk("uh_misalign_w", misalign_w, 1'b0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_stage.md
# mem_stage

MIPS memory-access stage sitting directly downstream of the EX/MEM pipeline register. It takes the EX/MEM control and data outputs and drives a request/acknowledge data-memory port. It stalls the pipeline while an access is outstanding and produces the registered MEM/WB values for writeback. It also reports misaligned and timed-out accesses as registered error flags.

## Interface
Parameters:
- TIMEOUT, 16: max wait cycles for dmem_ack before abort; legal range 1..255.

Ports (one clock; reset is synchronous and active-high):
- clk  in  1  pipeline clock; all state updates on rising edge
- reset  in  1  synchronous, active-high
- regwrite_m  in  1  instruction writes the register file
- memtoreg_m  in  1  writeback selects load data
- memwrite_m  in  1  store
- memread_m  in  1  load
- aluout_m  in  32  effective address / ALU result
- writedata_m  in  32  store data
- writereg_m  in  5  destination register
- size_m  in  2  only with MEM_BYTE_EN: 00 byte, 01 half, 10 word
- unsigned_m  in  1  only with MEM_BYTE_EN: zero-extend loads
- dmem_req  out  1  access request
- dmem_we  out  1  write enable; qualifies dmem_req
- dmem_addr  out  32  word address, {aluout_m[31:2],2'b00}
- dmem_wdata  out  32  lane-aligned store data
- dmem_be  out  4  byte enables
- dmem_ack  in  1  access complete this cycle
- dmem_rdata  in  32  read data; valid with dmem_ack
- stall_m  out  1  freeze IF..EX/MEM this cycle
- regwrite_w, memtoreg_w  out  1 each  MEM/WB control
- readdata_w, aluout_w  out  32 each  MEM/WB data
- writereg_w  out  5  MEM/WB destination
- misalign_w, buserr_w  out  1 each  registered error flags for the instruction in WB

## Operation
- An access is active when memread_m | memwrite_m. If both are set, treat the access as a store.
- Misalignment: word access with addr[1:0]≠0, or half access with addr[0]≠0.
  - No request is issued and the stage does not stall.
  - WB gets misalign_w=1 and regwrite_w=0.
- FSM states: IDLE, WAIT.
- IDLE:
  - On an aligned access, dmem_req=1 combinationally.
  - If dmem_ack arrives the same cycle, the access completes and the FSM stays in IDLE.
  - Otherwise stall_m=1, the FSM moves to WAIT, and the wait counter loads 1.
- WAIT:
  - dmem_req stays 1. Upstream is frozen, so the address and data are held stable.
  - stall_m=1 until completion.
  - On dmem_ack: the access completes, stall_m=0 that cycle, and the FSM returns to IDLE.
  - When the counter reaches TIMEOUT with no ack: abort, stall_m=0, buserr_w=1 and regwrite_w=0 in WB, return to IDLE.
- MEM/WB register:
  - Loads on every non-stalled cycle.
  - On stalled cycles it loads a bubble: regwrite_w=0, memtoreg_w=0, error flags 0. Data fields are don't-care but held.
- Load data: readdata_w captures the extended dmem_rdata on completion.
- Non-memory instructions pass through with one cycle of latency and no stall.

## Timing
- Reset values: every output is 0, including dmem_req, stall_m, and all *_w fields. FSM goes to IDLE and the counter clears.
- Reset while in WAIT: the request is dropped in the same cycle reset is sampled, and no completion is written to WB.
- Latency: zero-wait memory gives 1 cycle to WB. Each wait cycle adds 1 cycle.
- An ack that arrives in the same cycle the counter hits TIMEOUT counts as success.
- An ack while dmem_req=0 is ignored.

## Configuration
- MEM_BYTE_EN defined:
  - Enables the size_m and unsigned_m ports.
  - dmem_be is decoded from size and addr[1:0].
  - Stores replicate the byte or half across lanes.
  - Loads select the lane, then sign- or zero-extend.
- MEM_BYTE_EN undefined:
  - The size_m and unsigned_m ports are absent.
  - All accesses are word accesses and dmem_be=4'hF.
  - dmem_wdata=writedata_m and readdata_w=dmem_rdata.

## Structure
- Shared definitions file, `include'd: FSM state encodings (IDLE/WAIT), size encodings (SZ_BYTE/SZ_HALF/SZ_WORD), and the default TIMEOUT.
- One sub-module, load_extend: lane select plus sign/zero extension. It is instantiated only under MEM_BYTE_EN.

## Test plan
- ALU pass-through: regwrite_m=1, aluout_m=32'h1234, writereg_m=5'h0A, no access -> next cycle regwrite_w=1, aluout_w=32'h1234, writereg_w=5'h0A, stall_m never 1.
- Zero-wait load: memread_m=1, aluout_m=32'h100, ack same cycle with rdata=32'hDEADBEEF -> dmem_addr=32'h100, no stall, next cycle readdata_w=32'hDEADBEEF, memtoreg_w=1.
- Store with 3 wait cycles:
  - Stimulus: memwrite_m=1, addr 32'h200, data 32'h6790; ack on the 4th cycle.
  - Required: stall_m=1 for 3 cycles, dmem_we=1, dmem_be=4'hF throughout, WB holds bubbles during the stall, no regwrite.
- Timeout with TIMEOUT=4 and no ack -> stall_m=1 for 4 cycles, then buserr_w=1, regwrite_w=0, FSM back in IDLE.
- Misaligned word load at 32'h102 -> dmem_req=0, misalign_w=1 next cycle; reset asserted mid-WAIT -> dmem_req=0 and all outputs 0 after that edge.
- With MEM_BYTE_EN: signed byte load at 32'h103, rdata=32'h80000000 -> dmem_be=4'b1000, readdata_w=32'hFFFFFF80.
